// File: rtl/ga_alu_issuer.sv
// GA ALU initiator: buffers two multivector operands written one coefficient at a time,
// runs the valid / ready(1,0,1) handshake with a timeout guard, and keeps a readable result buffer.
package ga_pkg;
  localparam int unsigned GaDataWidth = 32;
  localparam int unsigned GaNumCoeffs = 32;

  typedef enum logic [3:0] {
    GA_FUNCT_ADD     = 4'd0,
    GA_FUNCT_SUB     = 4'd1,
    GA_FUNCT_GEO     = 4'd2,
    GA_FUNCT_OUTER   = 4'd3,
    GA_FUNCT_INNER   = 4'd4,
    GA_FUNCT_DUAL    = 4'd5,
    GA_FUNCT_REVERSE = 4'd6
  } ga_funct_e;

  // Element k is coefficient k in field order: 0 = scalar ... 31 = e123oi.
  typedef logic [GaNumCoeffs-1:0][GaDataWidth-1:0] ga_multivector_t;
endpackage

module ga_alu_issuer
  import ga_pkg::*;
#(
  parameter int unsigned DataWidth     = GaDataWidth,
  parameter int unsigned NumCoeffs     = GaNumCoeffs,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic                 wr_sel_i,
  input  logic [4:0]           wr_idx_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  ga_funct_e            op_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 timeout_o,
  input  logic [4:0]           rd_idx_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 alu_valid_o,
  input  logic                 alu_ready_i,
  output ga_funct_e            alu_operation_o,
  output ga_multivector_t      alu_operand_a_o,
  output ga_multivector_t      alu_operand_b_o,
  input  ga_multivector_t      alu_result_i,
  input  logic                 alu_error_i
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    COMPLETE
  } state_e;

  state_e                              state_q, state_d;
  logic [CntW-1:0]                     cnt_q;
  logic [NumCoeffs-1:0][DataWidth-1:0] opa_q, opb_q, res_q;
  ga_funct_e                           op_q;
  logic                                err_q, to_q;
  logic                                timed, capture, abort;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    abort   = 1'b0;
    timed   = (state_q == ISSUE) || (state_q == WAIT_ACK) || (state_q == WAIT_DONE);
    case (state_q)
      IDLE:      if (start_i) state_d = ISSUE;
      ISSUE:     if (alu_ready_i) state_d = WAIT_ACK;
      WAIT_ACK:  if (!alu_ready_i) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (alu_ready_i) begin
          capture = 1'b1;
          state_d = COMPLETE;
        end
      end
      COMPLETE:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // A capture on the final counted edge still completes normally.
    if (timed && !capture && (cnt_q == CntW'(TimeoutCycles - 1))) begin
      abort   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      op_q    <= GA_FUNCT_ADD;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (wr_en_i) begin
          if (wr_sel_i) opb_q[wr_idx_i] <= wr_data_i;
          else          opa_q[wr_idx_i] <= wr_data_i;
        end
        if (start_i) begin
          op_q  <= op_i;
          err_q <= 1'b0;
          to_q  <= 1'b0;
          cnt_q <= '0;
        end
      end
      if (timed) cnt_q <= cnt_q + 1'b1;
      if (capture) begin
        res_q <= alu_result_i;
        err_q <= alu_error_i;
      end
      if (abort) begin
        err_q <= 1'b1;
        to_q  <= 1'b1;
      end
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == COMPLETE);
  assign alu_valid_o     = (state_q == ISSUE);
  assign error_o         = err_q;
  assign timeout_o       = to_q;
  assign alu_operation_o = op_q;
  assign alu_operand_a_o = opa_q;
  assign alu_operand_b_o = opb_q;
  assign rd_data_o       = res_q[rd_idx_i];

endmodule

// File: tb/tb_ga_alu_issuer.sv
// Bench for ga_alu_issuer: directed handshake/timeout/reset scenarios plus randomized
// transactions checked against a coefficient-array model and an ALU stub.
module tb_ga_alu_issuer;
  import ga_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en_i = 1'b0;
  logic            wr_sel_i = 1'b0;
  logic [4:0]      wr_idx_i = '0;
  logic [31:0]     wr_data_i = '0;
  ga_funct_e       op_i = GA_FUNCT_ADD;
  logic            start_i = 1'b0;
  logic            busy_o, done_o, error_o, timeout_o;
  logic [4:0]      rd_idx_i = '0;
  logic [31:0]     rd_data_o;
  logic            alu_valid_o;
  logic            alu_ready_i = 1'b1;
  ga_funct_e       alu_operation_o;
  ga_multivector_t alu_operand_a_o, alu_operand_b_o;
  ga_multivector_t alu_result_i = '0;
  logic            alu_error_i = 1'b0;

  always #5 clk = ~clk;

  ga_alu_issuer #(.DataWidth(32), .NumCoeffs(32), .TimeoutCycles(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .op_i(op_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .timeout_o(timeout_o),
    .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_operation_o(alu_operation_o),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_result_i(alu_result_i), .alu_error_i(alu_error_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] mres [32];
  logic        merr = 1'b0;

  function automatic logic [31:0] alu_fn(ga_funct_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      GA_FUNCT_ADD: return a + b;
      GA_FUNCT_SUB: return a - b;
      default:      return a ^ b;
    endcase
  endfunction

  // ALU stub: optional backpressure, configurable compute time, or hang after the ack.
  int              bp_cfg = 0;
  int              comp_cfg = 1;
  bit              hang_cfg = 1'b0;
  int              st_phase = 0;
  int              st_bp = 0;
  int              st_comp = 0;
  ga_multivector_t stub_res = '0;
  logic            stub_err = 1'b0;

  always @(negedge clk) begin
    case (st_phase)
      0: begin
        if (alu_valid_o) begin
          if (st_bp > 0) begin
            alu_ready_i = 1'b0;
            st_bp--;
          end else begin
            alu_ready_i = 1'b1;
            st_phase = 1;
            for (int i = 0; i < 32; i++)
              stub_res[i] = alu_fn(alu_operation_o, alu_operand_a_o[i], alu_operand_b_o[i]);
            stub_err = (alu_operation_o == GA_FUNCT_GEO);
          end
        end else begin
          alu_ready_i = 1'b1;
          st_bp = bp_cfg;
        end
      end
      1: begin
        alu_ready_i = 1'b0;
        st_comp = comp_cfg;
        st_phase = 2;
        for (int i = 0; i < 32; i++) alu_result_i[i] = $urandom;
        alu_error_i = 1'b1;
      end
      default: begin
        if (!hang_cfg && st_comp <= 1) begin
          alu_ready_i = 1'b1;
          alu_result_i = stub_res;
          alu_error_i = stub_err;
          st_phase = 0;
        end else begin
          alu_ready_i = 1'b0;
          st_comp--;
          for (int i = 0; i < 32; i++) alu_result_i[i] = $urandom;
          alu_error_i = 1'b1;
        end
      end
    endcase
    if (st_phase != 0 && !busy_o) st_phase = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_idx_i = 5'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), rd_data_o, mres[i]);
    end
    rd_idx_i = '0;
  endtask

  task automatic write_coef(input bit sel, input int idx, input logic [31:0] data);
    @(negedge clk);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_idx_i = 5'(idx); wr_data_i = data;
    if (sel) mb[idx] = data; else ma[idx] = data;
    @(posedge clk);
    #1 wr_en_i = 1'b0;
  endtask

  task automatic model_capture(input ga_funct_e op);
    for (int i = 0; i < 32; i++) mres[i] = alu_fn(op, ma[i], mb[i]);
    merr = (op == GA_FUNCT_GEO);
  endtask

  // Launches one transaction and observes it cycle by cycle (k = cycles after the start cycle).
  task automatic run_txn(input ga_funct_e op, input int bp, input int comp, input bit hg,
                         input bit cw, input bit cw_sel, input int cw_idx, input logic [31:0] cw_data,
                         input int inj_k,
                         output int done_lat, output int done_cnt, output int valid_cyc,
                         output int busy_cyc, output bit stable, output logic [1:0] flags_k1);
    done_lat = -1; done_cnt = 0; valid_cyc = 0; busy_cyc = 0; stable = 1'b1; flags_k1 = 2'bxx;
    @(negedge clk);
    bp_cfg = bp; comp_cfg = comp; hang_cfg = hg;
    @(negedge clk);
    start_i = 1'b1; op_i = op;
    if (cw) begin
      wr_en_i = 1'b1; wr_sel_i = cw_sel; wr_idx_i = 5'(cw_idx); wr_data_i = cw_data;
      if (cw_sel) mb[cw_idx] = cw_data; else ma[cw_idx] = cw_data;
    end
    @(negedge clk);
    start_i = 1'b0; wr_en_i = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) flags_k1 = {error_o, timeout_o};
      if (!busy_o) break;
      if (k == inj_k) begin
        wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_idx_i = '0; wr_data_i = 32'd99;
        start_i = 1'b1; op_i = GA_FUNCT_SUB;
      end else begin
        wr_en_i = 1'b0; start_i = 1'b0;
      end
      busy_cyc++;
      if (alu_valid_o) valid_cyc++;
      if (done_o) begin
        done_cnt++;
        if (done_lat < 0) done_lat = k;
      end
      if (alu_operation_o !== op) stable = 1'b0;
      for (int i = 0; i < 32; i++)
        if (alu_operand_a_o[i] !== ma[i] || alu_operand_b_o[i] !== mb[i]) stable = 1'b0;
    end
    wr_en_i = 1'b0; start_i = 1'b0;
  endtask

  int         lat, dcnt, vcyc, bcyc, rdone;
  bit         stab;
  logic [1:0] fl;

  initial begin
    for (int i = 0; i < 32; i++) begin ma[i] = '0; mb[i] = '0; mres[i] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", alu_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_opa0", alu_operand_a_o[0], 0);
    chk_results("rst");
    @(negedge clk) rst = 1'b0;

    // ADD: 5 + 7, nominal ALU
    write_coef(0, 0, 32'd5);
    write_coef(1, 0, 32'd7);
    run_txn(GA_FUNCT_ADD, 0, 1, 0, 0, 0, 0, 0, 0, lat, dcnt, vcyc, bcyc, stab, fl);
    model_capture(GA_FUNCT_ADD);
    chk("add_done_lat", lat, 4);
    chk("add_done_cnt", dcnt, 1);
    chk("add_busy_cyc", bcyc, 4);
    chk("add_valid_cyc", vcyc, 1);
    chk("add_stable", stab, 1);
    chk("add_error", error_o, 0);
    rd_idx_i = 5'd0; #1;
    chk("add_rd0", rd_data_o, 32'd12);
    chk_results("add");

    // SUB: 3 - 10 on coefficient 1, everything else zero
    write_coef(0, 0, 32'd0);
    write_coef(1, 0, 32'd0);
    write_coef(0, 1, 32'd3);
    write_coef(1, 1, 32'd10);
    run_txn(GA_FUNCT_SUB, 0, 1, 0, 0, 0, 0, 0, 0, lat, dcnt, vcyc, bcyc, stab, fl);
    model_capture(GA_FUNCT_SUB);
    chk("sub_done_lat", lat, 4);
    rd_idx_i = 5'd1; #1;
    chk("sub_rd1", rd_data_o, 32'hFFFF_FFF9);
    chk_results("sub");

    // Backpressure: ready low for 3 cycles during ISSUE
    write_coef(0, 7, 32'hDEAD_BEEF);
    run_txn(GA_FUNCT_ADD, 3, 1, 0, 0, 0, 0, 0, 0, lat, dcnt, vcyc, bcyc, stab, fl);
    model_capture(GA_FUNCT_ADD);
    chk("bp_valid_cyc", vcyc, 4);
    chk("bp_done_lat", lat, 7);
    chk("bp_done_cnt", dcnt, 1);
    chk("bp_stable", stab, 1);
    chk_results("bp");

    // Hung ALU: timeout after 64 cycles, result buffer untouched
    run_txn(GA_FUNCT_SUB, 0, 1, 1, 0, 0, 0, 0, 0, lat, dcnt, vcyc, bcyc, stab, fl);
    chk("to_busy_cyc", bcyc, 64);
    chk("to_done_cnt", dcnt, 0);
    chk("to_timeout", timeout_o, 1);
    chk("to_error", error_o, 1);
    chk("to_busy", busy_o, 0);
    chk_results("to");
    run_txn(GA_FUNCT_ADD, 0, 1, 0, 0, 0, 0, 0, 0, lat, dcnt, vcyc, bcyc, stab, fl);
    model_capture(GA_FUNCT_ADD);
    chk("to_flags_cleared", 32'(fl), 0);
    chk("to_recover_lat", lat, 4);
    chk("to_recover_timeout", timeout_o, 0);

    // Write + start during WAIT_DONE are ignored
    write_coef(0, 0, 32'd41);
    run_txn(GA_FUNCT_ADD, 0, 4, 0, 0, 0, 0, 0, 4, lat, dcnt, vcyc, bcyc, stab, fl);
    model_capture(GA_FUNCT_ADD);
    chk("ign_done_cnt", dcnt, 1);
    chk("ign_done_lat", lat, 7);
    chk("ign_stable", stab, 1);
    repeat (3) @(negedge clk);
    chk("ign_busy_after", busy_o, 0);
    chk("ign_opa0", alu_operand_a_o[0], 32'd41);
    chk_results("ign");

    // Asynchronous reset during WAIT_DONE
    @(negedge clk);
    bp_cfg = 0; comp_cfg = 6; hang_cfg = 1'b0;
    @(negedge clk);
    start_i = 1'b1; op_i = GA_FUNCT_SUB;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy_before", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_valid", alu_valid_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_done", done_o, 0);
    chk("mid_opa0", alu_operand_a_o[0], 0);
    for (int i = 0; i < 32; i++) begin ma[i] = '0; mb[i] = '0; mres[i] = '0; end
    merr = 1'b0;
    chk_results("mid");
    @(negedge clk) rst = 1'b0;
    rdone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o) rdone++;
    end
    chk("mid_no_done", rdone, 0);
    chk("mid_error", error_o, 0);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      int        nw, bp, comp;
      ga_funct_e op;
      bit        cw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        write_coef(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
      op = ga_funct_e'($urandom_range(0, 2));
      bp = $urandom_range(0, 3);
      comp = $urandom_range(1, 4);
      cw = 1'($urandom_range(0, 1));
      run_txn(op, bp, comp, 0, cw, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
              0, lat, dcnt, vcyc, bcyc, stab, fl);
      model_capture(op);
      chk($sformatf("rnd%0d_lat", t), lat, 3 + bp + comp);
      chk($sformatf("rnd%0d_done_cnt", t), dcnt, 1);
      chk($sformatf("rnd%0d_valid_cyc", t), vcyc, bp + 1);
      chk($sformatf("rnd%0d_stable", t), stab, 1);
      chk($sformatf("rnd%0d_error", t), error_o, merr);
      chk($sformatf("rnd%0d_timeout", t), timeout_o, 0);
      chk_results($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
